// File: rtl/wbu_pkg.sv
// Shared constants for the bus-to-serial word path.
package wbu_pkg;

  localparam int unsigned WBU_CW = 36;

  localparam logic [WBU_CW-1:0] WBU_IDLE_WORD      = 36'h0_0000_0000;
  localparam logic [WBU_CW-1:0] WBU_BUSY_IDLE_WORD = 36'h0_8000_0000;
  localparam logic [WBU_CW-1:0] WBU_INT_WORD       = 36'h1_0000_0000;

  // Source selected for a load into the output register.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_DATA,
    SRC_INT,
    SRC_IDLE
  } wbu_src_e;

endpackage

// File: rtl/wbuidleint.sv
// Merges bus-response codewords, interrupt notifications and idle
// keep-alive words into a single one-deep output register.
module wbuidleint
  import wbu_pkg::*;
#(
  parameter int unsigned LGIDLE = 26
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stb,
  input  logic [WBU_CW-1:0] i_codword,
  input  logic              i_bus_busy,
  input  logic              i_interrupt,
  input  logic              i_tx_busy,
  output logic              o_int_stb,
  output logic [WBU_CW-1:0] o_int_word,
  output logic              o_busy
);

  logic              r_int_last;
  logic              int_pending;
  logic [LGIDLE-1:0] idle_cnt;

  wbu_src_e          src;
  logic              load;
  logic              idle_sat;
  logic              int_rise;
  logic [WBU_CW-1:0] load_word;

  assign o_busy = o_int_stb;

  // Priority select of the next word: data, then interrupt, then idle.
  always_comb begin
    src       = SRC_NONE;
    load_word = WBU_IDLE_WORD;
    idle_sat  = &idle_cnt;
    int_rise  = i_interrupt & ~r_int_last;
    if (!o_int_stb) begin
      if (i_stb) begin
        src = SRC_DATA;
      end else if (int_pending) begin
        src = SRC_INT;
      end else if (idle_sat) begin
        src = SRC_IDLE;
      end
    end
    case (src)
      SRC_DATA: load_word = i_codword;
      SRC_INT:  load_word = WBU_INT_WORD;
      SRC_IDLE: load_word = i_bus_busy ? WBU_BUSY_IDLE_WORD : WBU_IDLE_WORD;
      default:  load_word = WBU_IDLE_WORD;
    endcase
    load = (src != SRC_NONE);
  end

  // Output register: load when empty, drain when the splitter is free.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_int_stb  <= 1'b0;
      o_int_word <= '0;
    end else if (load) begin
      o_int_stb  <= 1'b1;
      o_int_word <= load_word;
    end else if (!i_tx_busy) begin
      o_int_stb  <= 1'b0;
    end
  end

  // Interrupt edge detector; a new rise beats a same-cycle clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_int_last  <= 1'b0;
      int_pending <= 1'b0;
    end else begin
      r_int_last  <= i_interrupt;
      int_pending <= int_rise | (int_pending & (src != SRC_INT));
    end
  end

  // Keep-alive timer: restarts on every load, saturates at all-ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idle_cnt <= '0;
    end else if (load) begin
      idle_cnt <= '0;
    end else if (!idle_sat) begin
      idle_cnt <= idle_cnt + LGIDLE'(1);
    end
  end

endmodule

// File: tb/tb_wbuidleint.sv
// Directed bench for wbuidleint with a 16-cycle idle period.
module tb_wbuidleint;
  import wbu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb;
  logic [35:0] codword;
  logic        bus_busy;
  logic        interrupt;
  logic        tx_busy;
  logic        int_stb;
  logic [35:0] int_word;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cnt;
  int cnt2;

  wbuidleint #(.LGIDLE(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_stb      (stb),
    .i_codword  (codword),
    .i_bus_busy (bus_busy),
    .i_interrupt(interrupt),
    .i_tx_busy  (tx_busy),
    .o_int_stb  (int_stb),
    .o_int_word (int_word),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; codword = '0; bus_busy = 1'b0;
    interrupt = 1'b0; tx_busy = 1'b0;
    step(2);
    chk("rst_stb", 36'(int_stb), 36'h0);
    chk("rst_word", int_word, 36'h0);
    chk("rst_busy", 36'(busy), 36'h0);
    // edge 0: release reset
    rst = 1'b0;

    // idle words every 16 cycles
    step(15);
    chk("idle1_early", 36'(int_stb), 36'h0);
    step(1);
    chk("idle1_stb", 36'(int_stb), 36'h1);
    chk("idle1_word", int_word, WBU_IDLE_WORD);
    chk("idle1_busy", 36'(busy), 36'h1);
    step(1);
    chk("idle1_drain", 36'(int_stb), 36'h0);
    step(14);
    chk("idle2_early", 36'(int_stb), 36'h0);
    step(1);
    chk("idle2_word", int_word, WBU_IDLE_WORD);
    chk("idle2_stb", 36'(int_stb), 36'h1);
    bus_busy = 1'b1;
    step(15);
    chk("bidle_early", 36'(int_stb), 36'h0);
    step(1);
    chk("bidle_stb", 36'(int_stb), 36'h1);
    chk("bidle_word", int_word, WBU_BUSY_IDLE_WORD);
    bus_busy = 1'b0;
    step(1);
    chk("bidle_drain", 36'(int_stb), 36'h0);

    // data path (edge 50)
    stb = 1'b1; codword = 36'h2_1234_5678;
    step(1);
    chk("data_stb", 36'(int_stb), 36'h1);
    chk("data_word", int_word, 36'h2_1234_5678);
    chk("data_busy", 36'(busy), 36'h1);
    stb = 1'b0;
    step(1);
    chk("data_drain", 36'(int_stb), 36'h0);
    chk("data_busy0", 36'(busy), 36'h0);

    // backpressure (edge 52)
    tx_busy = 1'b1; stb = 1'b1; codword = 36'h2_AAAA_0001;
    step(1);
    chk("bp_load", int_word, 36'h2_AAAA_0001);
    codword = 36'h2_BBBB_0002;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("bp_hold_stb", 36'(int_stb), 36'h1);
      chk("bp_hold_word", int_word, 36'h2_AAAA_0001);
      chk("bp_hold_busy", 36'(busy), 36'h1);
    end
    tx_busy = 1'b0;
    step(1);
    chk("bp_drain", 36'(int_stb), 36'h0);
    step(1);
    chk("bp_second_stb", 36'(int_stb), 36'h1);
    chk("bp_second_word", int_word, 36'h2_BBBB_0002);
    stb = 1'b0;
    step(1);
    chk("bp_second_drain", 36'(int_stb), 36'h0);

    // interrupt held high (edge 61)
    interrupt = 1'b1;
    step(1);
    chk("int_pend_cycle", 36'(int_stb), 36'h0);
    step(1);
    chk("int_stb", 36'(int_stb), 36'h1);
    chk("int_word", int_word, WBU_INT_WORD);
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 38; i++) begin
      step(1);
      if (int_stb && int_word == WBU_INT_WORD) cnt++;
      if (int_stb && int_word == WBU_IDLE_WORD) cnt2++;
    end
    chk("int_level_once", 36'(cnt), 36'd0);
    chk("int_level_idles", 36'(cnt2), 36'd2);
    interrupt = 1'b0;
    step(1);
    interrupt = 1'b1;
    step(1);
    chk("int2_pend_cycle", 36'(int_stb), 36'h0);
    step(1);
    chk("int2_word", int_word, WBU_INT_WORD);
    chk("int2_stb", 36'(int_stb), 36'h1);
    interrupt = 1'b0;
    step(1);
    chk("int2_drain", 36'(int_stb), 36'h0);

    // collision at edge 119: data, interrupt rise and saturated counter
    step(14);
    chk("col_pre", 36'(int_stb), 36'h0);
    stb = 1'b1; codword = 36'h2_CCCC_0003; interrupt = 1'b1;
    step(1);
    chk("col_data", int_word, 36'h2_CCCC_0003);
    chk("col_data_stb", 36'(int_stb), 36'h1);
    stb = 1'b0;
    step(1);
    chk("col_drain", 36'(int_stb), 36'h0);
    step(1);
    chk("col_int", int_word, WBU_INT_WORD);
    chk("col_int_stb", 36'(int_stb), 36'h1);
    interrupt = 1'b0;
    step(1);
    chk("col_int_drain", 36'(int_stb), 36'h0);
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      step(1);
      if (int_stb) cnt++;
    end
    chk("col_no_early_idle", 36'(cnt), 36'd0);
    step(1);
    chk("col_idle_stb", 36'(int_stb), 36'h1);
    chk("col_idle_word", int_word, WBU_IDLE_WORD);
    step(1);

    // reset while holding a word with an interrupt pending
    tx_busy = 1'b1; stb = 1'b1; codword = 36'h2_DDDD_0004; interrupt = 1'b1;
    step(1);
    chk("rh_load", int_word, 36'h2_DDDD_0004);
    stb = 1'b0;
    step(1);
    chk("rh_hold", 36'(int_stb), 36'h1);
    rst = 1'b1;
    #1;
    chk("rh_async_stb", 36'(int_stb), 36'h0);
    chk("rh_async_word", int_word, 36'h0);
    chk("rh_async_busy", 36'(busy), 36'h0);
    interrupt = 1'b0;
    step(1);
    rst = 1'b0; tx_busy = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (int_stb) cnt++;
    end
    chk("rh_no_int", 36'(cnt), 36'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
